// File: rtl/ntt_stream_ctrl_if.sv
// Coefficient stream port between the host-side sequencer (master) and the serial NTT engine (slave).
interface ntt_stream_ctrl_if;
  logic        o_ntt_ready;
  logic        o_ntt_intt;
  logic [15:0] o_ntt_data;
  logic        i_ntt_valid;
  logic [15:0] i_ntt_data;

  modport master (output o_ntt_ready, o_ntt_intt, o_ntt_data,
                  input  i_ntt_valid, i_ntt_data);
  modport slave  (input  o_ntt_ready, o_ntt_intt, o_ntt_data,
                  output i_ntt_valid, i_ntt_data);
endinterface

// File: rtl/ntt_stream_ctrl.sv
// Streams a 256-coefficient polynomial into the NTT engine, then captures the result,
// reduces each word to [0, 3328] and writes it back in place.
module ntt_stream_ctrl #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_addr,
  input  logic [15:0]       i_wr_data,
  input  logic [7:0]        i_rd_addr,
  output logic [15:0]       o_rd_data,
  input  logic              i_start,
  input  logic              i_intt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  ntt_stream_ctrl_if.master ntt
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [16:0] Q         = 17'd3329;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] idle_q, idle_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        intt_q, intt_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rd_q, rd_d;

  logic [15:0] buf_q [256];
  logic        mem_we;
  logic [7:0]  mem_wa;
  logic [15:0] mem_wd;

  // Barrett reduction: offset x by 10*q so the operand is non-negative (522..66057),
  // then the quotient estimate with m = floor(2^24/q) is short by at most one.
  logic [16:0] red_u;
  logic [5:0]  red_qe;
  logic [16:0] red_r;
  logic [15:0] red_val;

  always_comb begin
    red_u   = {1'b0, ~ntt.i_ntt_data[15], ntt.i_ntt_data[14:0]} + 17'd522;
    red_qe  = 6'((30'(red_u) * 30'd5039) >> 24);
    red_r   = red_u - (17'(red_qe) * Q);
    red_val = (red_r >= Q) ? 16'(red_r - Q) : 16'(red_r);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    err_d   = err_q;
    intt_d  = intt_q;
    done_d  = 1'b0;
    ready_d = 1'b0;
    data_d  = '0;
    mem_we  = 1'b0;
    mem_wa  = i_wr_addr;
    mem_wd  = i_wr_data;
    case (state_q)
      S_IDLE: begin
        mem_we = i_wr_en;
        if (i_start) begin
          state_d = S_SEND;
          cnt_d   = '0;
          idle_d  = '0;
          err_d   = 1'b0;
          intt_d  = i_intt;
          ready_d = 1'b1;
          // A same-cycle host write to word 0 must appear in the stream.
          data_d  = (i_wr_en && i_wr_addr == 8'd0) ? i_wr_data : buf_q[0];
        end
      end
      S_SEND: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd255) begin
          state_d = S_WAIT;
        end else begin
          ready_d = 1'b1;
          data_d  = buf_q[cnt_q + 8'd1];
        end
      end
      S_WAIT, S_RECV: begin
        mem_wa = cnt_q;
        mem_wd = red_val;
        if (idle_q == TIMEOUT_C) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (ntt.i_ntt_valid) begin
          mem_we  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          idle_d  = '0;
          state_d = (cnt_q == 8'd255) ? S_DONE : S_RECV;
          done_d  = (cnt_q == 8'd255);
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        intt_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    rd_d   = busy_d ? 16'd0 : buf_q[i_rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      intt_q  <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      intt_q  <= intt_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) buf_q[mem_wa] <= mem_wd;
  end

  assign o_rd_data       = rd_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign ntt.o_ntt_ready = ready_q;
  assign ntt.o_ntt_intt  = intt_q;
  assign ntt.o_ntt_data  = data_q;

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Scoreboard bench for ntt_stream_ctrl: expected stream/read words are queued when driven
// and compared when the DUT presents them.
module tb_ntt_stream_ctrl;
  localparam int TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst, i_wr_en, i_start, i_intt;
  logic [7:0]  i_wr_addr, i_rd_addr;
  logic [15:0] i_wr_data, o_rd_data;
  logic        o_busy, o_done, o_err;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem_m [256];
  logic [15:0] exp_q [$];
  logic [15:0] rd_q  [$];

  ntt_stream_ctrl_if eng_if ();

  ntt_stream_ctrl #(.TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .i_start(i_start), .i_intt(i_intt),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .ntt(eng_if.master)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] red_model(input logic [15:0] x);
    int v;
    v = int'($signed(x)) % 3329;
    if (v < 0) v += 3329;
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [15:0] d);
    i_wr_en   = 1'b1;
    i_wr_addr = 8'(a);
    i_wr_data = d;
    tick();
    i_wr_en   = 1'b0;
    mem_m[a]  = d;
  endtask

  task automatic fill_buffer(input int seed);
    for (int a = 0; a < 256; a++) host_write(a, 16'(a * 37 + seed));
  endtask

  task automatic start_run(input logic intt, input logic with_wr, input int a, input logic [15:0] d);
    i_start = 1'b1;
    i_intt  = intt;
    if (with_wr) begin
      i_wr_en = 1'b1; i_wr_addr = 8'(a); i_wr_data = d;
      mem_m[a] = d;
    end
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(mem_m[k]);
    tick();
    i_start = 1'b0;
    i_wr_en = 1'b0;
  endtask

  task automatic send_check(input logic intt, input string name, input int inject_at);
    for (int k = 0; k < 256; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (eng_if.o_ntt_ready !== 1'b1 || eng_if.o_ntt_data !== e || eng_if.o_ntt_intt !== intt) begin
        n_err++;
        $display("FAIL %s word %0d: ready=%b data=%h intt=%b, required ready=1 data=%h intt=%b",
                 name, k, eng_if.o_ntt_ready, eng_if.o_ntt_data, eng_if.o_ntt_intt, e, intt);
      end
      if (inject_at >= 0 && k == inject_at) begin
        i_start = 1'b1; i_wr_en = 1'b1; i_wr_addr = 8'd5; i_wr_data = 16'h7777; i_rd_addr = 8'd5;
      end
      if (inject_at >= 0 && k == inject_at + 1) begin
        i_start = 1'b0; i_wr_en = 1'b0;
        n_vec++;
        if (o_rd_data !== 16'd0) begin
          n_err++;
          $display("FAIL %s rd_while_busy: got %h, required 0000", name, o_rd_data);
        end
      end
      tick();
    end
    n_vec++;
    if (eng_if.o_ntt_ready !== 1'b0 || eng_if.o_ntt_data !== 16'd0 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_fall: ready=%b data=%h busy=%b, required ready=0 data=0000 busy=1",
               name, eng_if.o_ntt_ready, eng_if.o_ntt_data, o_busy);
    end
  endtask

  task automatic respond(input logic [15:0] words[$], input int n, input logic gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      eng_if.i_ntt_valid = 1'b1;
      eng_if.i_ntt_data  = words[i];
      mem_m[i] = red_model(words[i]);
      tick();
      eng_if.i_ntt_valid = 1'b0;
      eng_if.i_ntt_data  = 16'h0;
    end
  endtask

  task automatic finish_check(input logic intt, input logic err, input string name);
    n_vec++;
    if (o_done !== 1'b1 || o_busy !== 1'b1 || o_err !== err || eng_if.o_ntt_intt !== intt) begin
      n_err++;
      $display("FAIL %s done_pulse: done=%b busy=%b err=%b intt=%b, required done=1 busy=1 err=%b intt=%b",
               name, o_done, o_busy, o_err, eng_if.o_ntt_intt, err, intt);
    end
    tick();
    n_vec++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_err !== err || eng_if.o_ntt_intt !== 1'b0) begin
      n_err++;
      $display("FAIL %s back_to_idle: done=%b busy=%b err=%b intt=%b, required done=0 busy=0 err=%b intt=0",
               name, o_done, o_busy, o_err, eng_if.o_ntt_intt, err);
    end
  endtask

  task automatic read_check(input int lo, input int hi, input string name);
    for (int a = lo; a <= hi; a++) begin
      logic [15:0] e;
      i_rd_addr = 8'(a);
      rd_q.push_back(mem_m[a]);
      tick();
      e = rd_q.pop_front();
      n_vec++;
      if (o_rd_data !== e) begin
        n_err++;
        $display("FAIL %s read addr %0d: got %h, required %h", name, a, o_rd_data, e);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0 || eng_if.o_ntt_ready !== 1'b0 ||
        eng_if.o_ntt_intt !== 1'b0 || eng_if.o_ntt_data !== 16'd0 || o_rd_data !== 16'd0) begin
      n_err++;
      $display("FAIL %s: busy=%b done=%b err=%b ready=%b intt=%b data=%h rd=%h, required all zero",
               name, o_busy, o_done, o_err, eng_if.o_ntt_ready, eng_if.o_ntt_intt,
               eng_if.o_ntt_data, o_rd_data);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset_state");
    i_rst = 1'b0;
  endtask

  task automatic test_send_order();
    logic [15:0] w[$];
    for (int a = 1; a < 256; a++) host_write(a, 16'(a));
    host_write(0, 16'hFFFF);
    start_run(1'b0, 1'b1, 0, 16'h0000);
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL send_order busy_rise: got %b, required 1", o_busy);
    end
    send_check(1'b0, "send_order", -1);
    for (int k = 0; k < 256; k++) w.push_back(16'(k));
    respond(w, 256, 1'b0);
    finish_check(1'b0, 1'b0, "send_order");
    read_check(250, 255, "send_order");
  endtask

  task automatic test_reduction();
    logic [15:0] w[$];
    w = '{16'hFFFF, 16'd3329, 16'h8000, 16'h7FFF, 16'd1000};
    for (int k = 5; k < 256; k++) w.push_back(16'h0000);
    start_run(1'b0, 1'b0, 0, 16'h0);
    send_check(1'b0, "reduction", -1);
    respond(w, 256, 1'b1);
    finish_check(1'b0, 1'b0, "reduction");
    read_check(0, 7, "reduction");
  endtask

  task automatic test_timeout();
    logic [15:0] w[$];
    int cyc;
    fill_buffer(16'h1234);
    for (int i = 0; i < 10; i++) w.push_back(16'(i * 7001 - 30000));
    start_run(1'b1, 1'b0, 0, 16'h0);
    send_check(1'b1, "timeout", -1);
    respond(w, 10, 1'b0);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc != TMO + 1) begin
      n_err++;
      $display("FAIL timeout latency: done after %0d idle cycles, required %0d", cyc, TMO + 1);
    end
    finish_check(1'b1, 1'b1, "timeout");
    read_check(0, 255, "timeout");
  endtask

  task automatic test_dropped_while_busy();
    logic [15:0] w[$];
    int busy_cnt;
    for (int k = 0; k < 256; k++) w.push_back(16'($urandom_range(0, 65535)));
    start_run(1'b0, 1'b0, 0, 16'h0);
    send_check(1'b0, "dropped", 20);
    respond(w, 256, 1'b1);
    finish_check(1'b0, 1'b0, "dropped");
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_busy === 1'b1 || o_done === 1'b1) busy_cnt++;
      tick();
    end
    n_vec++;
    if (busy_cnt != 0) begin
      n_err++;
      $display("FAIL dropped second_run: busy/done seen %0d cycles, required 0", busy_cnt);
    end
    read_check(0, 10, "dropped");
  endtask

  task automatic test_reset_midrun();
    logic [15:0] w[$];
    int done_cnt;
    start_run(1'b0, 1'b0, 0, 16'h0);
    repeat (100) tick();
    exp_q.delete();
    i_rst = 1'b1;
    tick();
    check_reset_outputs("midrun_reset");
    i_rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (o_done === 1'b1 || o_busy === 1'b1) done_cnt++;
      tick();
    end
    n_vec++;
    if (done_cnt != 0) begin
      n_err++;
      $display("FAIL midrun_reset no_done: done/busy seen %0d cycles, required 0", done_cnt);
    end
    fill_buffer(16'h0BAD);
    for (int k = 0; k < 256; k++) w.push_back(16'($urandom_range(0, 65535)));
    start_run(1'b1, 1'b0, 0, 16'h0);
    send_check(1'b1, "restart", -1);
    respond(w, 256, 1'b1);
    finish_check(1'b1, 1'b0, "restart");
    read_check(0, 15, "restart");
  endtask

  initial begin
    i_rst = 1'b1; i_wr_en = 1'b0; i_start = 1'b0; i_intt = 1'b0;
    i_wr_addr = 8'd0; i_rd_addr = 8'd0; i_wr_data = 16'd0;
    eng_if.i_ntt_valid = 1'b0;
    eng_if.i_ntt_data  = 16'd0;
    test_reset();
    test_send_order();
    test_reduction();
    test_timeout();
    test_dropped_while_busy();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
